// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
// Purpose: bundles the EXE/MEM-to-MEM/WB control and data signals plus the
//          write-back, branch-redirect and status outputs of mem_wb_stage.
// Modports:
//   master - upstream pipeline / test driver: drives wb_en and mem_*,
//            observes branch_*, flush, wb_*, align_err, br_cnt.
//   slave  - mem_wb_stage itself.
interface mem_wb_stage_if #(
  parameter int CNTW = 16
) ();
  logic            wb_en;
  logic            mem_wreg;
  logic            mem_m2reg;
  logic            mem_wmem;
  logic            mem_beq;
  logic            mem_bne;
  logic [31:0]     mem_alu;
  logic [31:0]     mem_b;
  logic [4:0]      mem_rn;
  logic            mem_z;
  logic [31:0]     mem_target;

  logic            branch_taken;
  logic [31:0]     branch_pc;
  logic            flush;
  logic            wb_wreg;
  logic            wb_m2reg;
  logic [31:0]     wb_alu;
  logic [31:0]     wb_mo;
  logic [4:0]      wb_rn;
  logic [31:0]     wb_data;
  logic            align_err;
  logic [CNTW-1:0] br_cnt;

  modport master (
    output wb_en, mem_wreg, mem_m2reg, mem_wmem, mem_beq, mem_bne,
           mem_alu, mem_b, mem_rn, mem_z, mem_target,
    input  branch_taken, branch_pc, flush, wb_wreg, wb_m2reg, wb_alu,
           wb_mo, wb_rn, wb_data, align_err, br_cnt
  );

  modport slave (
    input  wb_en, mem_wreg, mem_m2reg, mem_wmem, mem_beq, mem_bne,
           mem_alu, mem_b, mem_rn, mem_z, mem_target,
    output branch_taken, branch_pc, flush, wb_wreg, wb_m2reg, wb_alu,
           wb_mo, wb_rn, wb_data, align_err, br_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// Purpose: memory stage plus MEM/WB pipeline register. Holds the
//          word-addressed data memory, resolves BEQ/BNE from the held Z
//          flag, registers ALU result and load data for write-back, and
//          keeps a sticky misalignment flag and a saturating taken-branch
//          counter.
// Ports:
//   i_clk - clock, all state updates on the rising edge
//   i_clr - synchronous active-high reset (overrides wb_en)
//   bus   - mem_wb_stage_if.slave: MEM-stage inputs, wb_en, write-back
//           register outputs, branch redirect/flush, align_err, br_cnt
module mem_wb_stage #(
  parameter int AW   = 6,
  parameter int CNTW = 16
) (
  input logic           i_clk,
  input logic           i_clr,
  mem_wb_stage_if.slave bus
);

  localparam int DEPTH = 1 << AW;

  logic [31:0]     r_mem [DEPTH];
  logic            r_wreg;
  logic            r_m2reg;
  logic [31:0]     r_alu;
  logic [31:0]     r_mo;
  logic [4:0]      r_rn;
  logic            r_align_err;
  logic [CNTW-1:0] r_br_cnt;

  logic [AW-1:0]   w_idx;
  logic            w_misalign;
  logic            w_store;
  logic            w_taken;
  logic [31:0]     w_rdata;
  logic            w_unused_addr;

  // Upper address bits are deliberately dropped: the memory aliases.
  assign w_idx         = bus.mem_alu[AW+1:2];
  assign w_unused_addr = ^bus.mem_alu[31:AW+2];

  assign w_misalign = (bus.mem_wmem | bus.mem_m2reg) & (bus.mem_alu[1:0] != 2'b00);

  // A stalled store is held in MEM and replayed, so it only commits on an
  // advancing edge.
  assign w_store = bus.mem_wmem & bus.wb_en & ~i_clr & ~w_misalign;

  // BEQ and BNE together is an illegal encoding and is treated as no branch.
  assign w_taken = ~i_clr & ~(bus.mem_beq & bus.mem_bne) &
                   ((bus.mem_beq & bus.mem_z) | (bus.mem_bne & ~bus.mem_z));

  // Asynchronous read; a store on the previous edge is already visible.
  assign w_rdata = r_mem[w_idx];

  // Memory contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_store) begin
      r_mem[w_idx] <= bus.mem_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_alu   <= 32'd0;
      r_mo    <= 32'd0;
      r_rn    <= 5'd0;
    end else if (bus.wb_en) begin
      r_wreg  <= bus.mem_wreg;
      r_m2reg <= bus.mem_m2reg;
      r_alu   <= bus.mem_alu;
      r_mo    <= w_rdata;
      r_rn    <= bus.mem_rn;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_align_err <= 1'b0;
    end else if (bus.wb_en && w_misalign) begin
      r_align_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_br_cnt <= '0;
    end else if (w_taken && bus.wb_en && (r_br_cnt != {CNTW{1'b1}})) begin
      r_br_cnt <= r_br_cnt + 1'b1;
    end
  end

  assign bus.branch_taken = w_taken;
  assign bus.branch_pc    = bus.mem_target;
  assign bus.flush        = w_taken;
  assign bus.wb_wreg      = r_wreg;
  assign bus.wb_m2reg     = r_m2reg;
  assign bus.wb_alu       = r_alu;
  assign bus.wb_mo        = r_mo;
  assign bus.wb_rn        = r_rn;
  assign bus.wb_data      = r_m2reg ? r_mo : r_alu;
  assign bus.align_err    = r_align_err;
  assign bus.br_cnt       = r_br_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
  localparam int AW   = 6;
  localparam int CNTW = 2;

  logic clk = 1'b0;
  logic clr;

  mem_wb_stage_if #(.CNTW(CNTW)) bus ();

  mem_wb_stage #(.AW(AW), .CNTW(CNTW)) dut (
    .i_clk (clk),
    .i_clr (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bt;
    logic [31:0] pc;
  } comb_t;

  typedef struct {
    logic            wreg;
    logic            m2reg;
    logic [31:0]     alu;
    logic [31:0]     mo;
    logic            chk_mo;
    logic [4:0]      rn;
    logic [CNTW-1:0] br;
    logic            al;
  } reg_t;

  comb_t q_c[$];
  reg_t  q_r[$];
  int    checks = 0;
  int    errors = 0;

  reg_t            e;
  logic [CNTW-1:0] e_br;
  logic            e_al;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one MEM-stage vector after a rising edge and queue what the DUT
  // must show: combinational outputs this cycle, registered ones after the
  // next edge.
  task automatic issue(input logic c, input logic en, input logic wreg,
                       input logic m2reg, input logic wmem, input logic beq,
                       input logic bne, input logic z, input logic [31:0] alu,
                       input logic [31:0] b, input logic [31:0] tgt,
                       input logic [4:0] rn, input logic bt, input logic chkmo,
                       input logic [31:0] mo);
    comb_t cc;
    @(posedge clk);
    #2;
    clr            = c;
    bus.wb_en      = en;
    bus.mem_wreg   = wreg;
    bus.mem_m2reg  = m2reg;
    bus.mem_wmem   = wmem;
    bus.mem_beq    = beq;
    bus.mem_bne    = bne;
    bus.mem_z      = z;
    bus.mem_alu    = alu;
    bus.mem_b      = b;
    bus.mem_target = tgt;
    bus.mem_rn     = rn;
    cc.bt = bt;
    cc.pc = tgt;
    q_c.push_back(cc);
    if (c) begin
      e.wreg = 1'b0; e.m2reg = 1'b0; e.alu = 32'd0; e.mo = 32'd0;
      e.chk_mo = 1'b1; e.rn = 5'd0;
    end else if (en) begin
      e.wreg = wreg; e.m2reg = m2reg; e.alu = alu; e.mo = mo;
      e.chk_mo = chkmo; e.rn = rn;
    end
    e.br = e_br;
    e.al = e_al;
    q_r.push_back(e);
  endtask

  task automatic rst();
    e_br = '0;
    e_al = 1'b0;
    issue(1, 1, 0, 0, 1, 0, 0, 0, 32'h10, 32'hDEAD, 32'h0, 5'd0, 0, 0, 32'h0);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic en);
    issue(0, en, 0, 0, 1, 0, 0, 0, a, d, 32'h0, 5'd0, 0, 0, 32'h0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [4:0] rn, input logic [31:0] mo);
    issue(0, 1, 1, 1, 0, 0, 0, 0, a, 32'h0, 32'h0, rn, 0, 1, mo);
  endtask

  task automatic alu_op(input logic [31:0] a, input logic [4:0] rn);
    issue(0, 1, 1, 0, 0, 0, 0, 0, a, 32'h0, 32'h0, rn, 0, 0, 32'h0);
  endtask

  task automatic brn(input logic beq, input logic bne, input logic z,
                     input logic [31:0] tgt, input logic bt, input logic en);
    issue(0, en, 0, 0, 0, beq, bne, z, 32'h0, 32'h0, tgt, 5'd0, bt, 0, 32'h0);
  endtask

  initial begin : mon_comb
    comb_t c;
    forever begin
      @(negedge clk);
      if (q_c.size() != 0) begin
        c = q_c.pop_front();
        chk("branch_taken", {31'd0, bus.branch_taken}, {31'd0, c.bt});
        chk("flush", {31'd0, bus.flush}, {31'd0, c.bt});
        chk("branch_pc", bus.branch_pc, c.pc);
      end
    end
  end

  initial begin : mon_reg
    reg_t r;
    forever begin
      @(posedge clk);
      #1;
      if (q_r.size() != 0) begin
        r = q_r.pop_front();
        chk("wb_wreg", {31'd0, bus.wb_wreg}, {31'd0, r.wreg});
        chk("wb_m2reg", {31'd0, bus.wb_m2reg}, {31'd0, r.m2reg});
        chk("wb_alu", bus.wb_alu, r.alu);
        chk("wb_rn", {27'd0, bus.wb_rn}, {27'd0, r.rn});
        chk("br_cnt", {{(32-CNTW){1'b0}}, bus.br_cnt}, {{(32-CNTW){1'b0}}, r.br});
        chk("align_err", {31'd0, bus.align_err}, {31'd0, r.al});
        if (r.chk_mo) begin
          chk("wb_mo", bus.wb_mo, r.mo);
        end
        if (!r.m2reg) begin
          chk("wb_data_alu", bus.wb_data, r.alu);
        end else if (r.chk_mo) begin
          chk("wb_data_mo", bus.wb_data, r.mo);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    clr = 1'b1;
    bus.wb_en = 1'b0; bus.mem_wreg = 1'b0; bus.mem_m2reg = 1'b0;
    bus.mem_wmem = 1'b0; bus.mem_beq = 1'b0; bus.mem_bne = 1'b0;
    bus.mem_z = 1'b0; bus.mem_alu = 32'h0; bus.mem_b = 32'h0;
    bus.mem_target = 32'h0; bus.mem_rn = 5'd0;
    e = '{default: '0};
    e_br = '0;
    e_al = 1'b0;

    // reset with a pending store; the store must not land
    rst(); rst();
    st(32'h10, 32'h0000_0BAD, 1);
    rst(); rst();
    ld(32'h10, 5'd3, 32'h0000_0BAD);

    // store then load back-to-back
    st(32'h20, 32'h1234_5678, 1);
    ld(32'h20, 5'd5, 32'h1234_5678);
    alu_op(32'hCAFE_F00D, 5'd7);

    // address wrap: 0x104 aliases 0x04
    st(32'h04, 32'hAAAA_0001, 1);
    ld(32'h104, 5'd6, 32'hAAAA_0001);

    // stall: held store is not written while wb_en=0
    st(32'h08, 32'h11, 1);
    alu_op(32'h77, 5'd9);
    st(32'h08, 32'h55, 0); st(32'h08, 32'h55, 0); st(32'h08, 32'h55, 0);
    ld(32'h08, 5'd10, 32'h11);
    st(32'h08, 32'h55, 0); st(32'h08, 32'h55, 0);
    st(32'h08, 32'h55, 1);
    ld(32'h08, 5'd11, 32'h55);

    // branches
    e_br = 2'd1; brn(1, 0, 1, 32'h400, 1, 1);
    brn(0, 1, 1, 32'h500, 0, 1);
    brn(1, 1, 1, 32'h600, 0, 1);
    brn(1, 1, 0, 32'h640, 0, 1);
    e_br = 2'd2; brn(0, 1, 0, 32'h700, 1, 1);
    brn(1, 0, 1, 32'h800, 1, 0);
    e_br = 2'd3; brn(1, 0, 1, 32'h900, 1, 1);
    brn(0, 1, 0, 32'hA00, 1, 1);
    brn(1, 0, 1, 32'hB00, 1, 1);

    // misalignment: store dropped, sticky flag, misaligned load still reads
    e_al = 1'b1; st(32'h22, 32'h99, 1);
    ld(32'h20, 5'd12, 32'h1234_5678);
    ld(32'h21, 5'd13, 32'h1234_5678);
    alu_op(32'h5, 5'd14);

    // reset with a branch presented: no redirect, flag and counter clear
    e_br = '0; e_al = 1'b0;
    issue(1, 1, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0, 32'hC00, 5'd0, 0, 0, 32'h0);
    alu_op(32'h6, 5'd15);

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q_c.size() != 0 || q_r.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d/%0d required=0/0", q_c.size(), q_r.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
